seven_seg_scan: RTL and testbench

- Time-multiplexed scanner for a common-anode multi-digit seven-segment display, driven from one shared 8-bit segment bus.
- Latches a multi-digit hex value plus per-digit blank and decimal-point masks through a load/ack handshake, and applies them only at frame boundaries so no tearing is visible.
- Sequences digits with a dwell period and an anti-ghosting guard gap.
- Supports leading-zero suppression and whole-display blinking for game-state indication (score, level, "game over").
- Instantiates the existing hex-to-segment decoder seven_seg, one instance on the shared bus.

---
 rtl/seven_seg_scan_pkg.sv | 11 +
 rtl/seven_seg_scan_if.sv | 24 ++
 rtl/seven_seg.sv | 26 ++
 rtl/seven_seg_scan.sv | 157 +++++++++++++++
 tb/tb_seven_seg_scan.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scan_pkg.sv
// rtl/seven_seg_scan_pkg.sv - shared types and constants for the seven-segment scanner
package seven_seg_scan_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [7:0] SEG_DARK = 8'hFF;

endpackage

// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - load handshake and display bus of the seven-segment scanner
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] hex_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    load_ack;
  logic                    blink_en;
  logic [7:0]              segments_n;
  logic [NUM_DIGITS-1:0]   digit_n;
  logic                    frame_done;

  modport master (
    output hex_in, blank_in, dp_in, load, blink_en,
    input  load_ack, segments_n, digit_n, frame_done
  );

  modport slave (
    input  hex_in, blank_in, dp_in, load, blink_en,
    output load_ack, segments_n, digit_n, frame_done
  );
endinterface

// File: rtl/seven_seg.sv
// rtl/seven_seg.sv - hex nibble to active-low g..a segment decoder
module seven_seg (
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);
  always_comb begin
    case (hex)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      default: seg_n = 7'h0E;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed common-anode display scanner with
// frame-synchronous loading, leading-zero suppression and blinking
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500,
  parameter int BLINK_FRAMES = 100,
  parameter int LZS_EN       = 1
) (
  input logic              clk,
  input logic              rst_n,
  seven_seg_scan_if.slave  bus
);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);

  scan_state_t             state;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] pend_hex, act_hex;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank, pend_dp, act_dp;
  logic                    pend_flag, act_valid;
  logic [BLK_W-1:0]        blk_cnt;
  logic                    blink_phase;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic                    ack_q, fd_q;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   lzs_dark;
  logic                    seen_nonzero;
  logic                    digit_lit;
  logic                    boundary;

  seven_seg u_dec (
    .hex   (nibble),
    .seg_n (dec_seg)
  );

  // Leading digits stay dark until the first nonzero one; digit 0 always shows.
  always_comb begin
    lzs_dark     = '0;
    seen_nonzero = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (act_hex[4*i +: 4] != 4'd0) seen_nonzero = 1'b1;
      lzs_dark[i] = (LZS_EN != 0) && !seen_nonzero;
    end
  end

  always_comb begin
    nibble    = act_hex[4*int'(idx) +: 4];
    digit_lit = act_valid && !act_blank[idx] && !lzs_dark[idx] && !(bus.blink_en && blink_phase);
    boundary  = (state == DRIVE) && (cnt == DWELL_LAST) && (idx == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GUARD;
      idx   <= '0;
      cnt   <= '0;
      seg_q <= SEG_DARK;
      dig_q <= '1;
      ack_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      fd_q  <= 1'b0;
      case (state)
        GUARD: begin
          if (cnt == GUARD_LAST) begin
            state <= DRIVE;
            cnt   <= '0;
            if (digit_lit) begin
              dig_q <= ~(NUM_DIGITS'(1) << idx);
              seg_q <= {~act_dp[idx], dec_seg};
            end else begin
              dig_q <= '1;
              seg_q <= SEG_DARK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == DWELL_LAST) begin
            state <= GUARD;
            cnt   <= '0;
            dig_q <= '1;
            seg_q <= SEG_DARK;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            fd_q  <= boundary;
            ack_q <= boundary && pend_flag;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // The boundary consumes the old pending value before a coincident load lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_hex    <= '0;
      pend_blank  <= '0;
      pend_dp     <= '0;
      pend_flag   <= 1'b0;
      act_hex     <= '0;
      act_blank   <= '0;
      act_dp      <= '0;
      act_valid   <= 1'b0;
      blk_cnt     <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (boundary && pend_flag) begin
        act_hex   <= pend_hex;
        act_blank <= pend_blank;
        act_dp    <= pend_dp;
        act_valid <= 1'b1;
      end
      if (bus.load) begin
        pend_hex   <= bus.hex_in;
        pend_blank <= bus.blank_in;
        pend_dp    <= bus.dp_in;
        pend_flag  <= 1'b1;
      end else if (boundary) begin
        pend_flag <= 1'b0;
      end
      if (!bus.blink_en) begin
        blk_cnt     <= '0;
        blink_phase <= 1'b0;
      end else if (boundary) begin
        if (blk_cnt == BLK_LAST) begin
          blk_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.segments_n = seg_q;
  assign bus.digit_n    = dig_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb/tb_seven_seg_scan.sv - self-checking bench for seven_seg_scan
module tb_seven_seg_scan;
  localparam int N     = 4;
  localparam int D     = 4;
  localparam int G     = 1;
  localparam int B     = 2;
  localparam int FRAME = N * (G + D);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan #(
    .NUM_DIGITS   (N),
    .DWELL_CYCLES (D),
    .GUARD_CYCLES (G),
    .BLINK_FRAMES (B),
    .LZS_EN       (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] seg_tab [0:15];
  int         k;
  logic [15:0] m_pend_hex, m_act_hex;
  logic [3:0]  m_pend_blank, m_act_blank, m_pend_dp, m_act_dp;
  bit          m_pend, m_valid;
  int          m_nb;
  logic [3:0]  e_dig;
  logic [7:0]  e_seg;
  logic        e_ack, e_fd;

  task automatic model_reset();
    k = 0;
    m_pend_hex = '0; m_act_hex = '0;
    m_pend_blank = '0; m_act_blank = '0; m_pend_dp = '0; m_act_dp = '0;
    m_pend = 0; m_valid = 0; m_nb = 0;
    e_dig = 4'hF; e_seg = 8'hFF; e_ack = 0; e_fd = 0;
  endtask

  // Position in the frame follows from the edge count since reset release.
  task automatic model_edge();
    int m, pos, slot, w, top;
    bit bnd, lit;
    logic [15:0] tmp;
    logic [3:0]  one;
    k++;
    e_ack = 0;
    e_fd  = 0;
    bnd   = 0;
    one   = 4'b0001;
    if (k >= G) begin
      m    = k - G;
      pos  = m % FRAME;
      slot = pos / (G + D);
      w    = pos % (G + D);
      bnd  = (pos == FRAME - G);
      if (w == 0) begin
        top = 0;
        for (int d = 0; d < N; d++) begin
          tmp = m_act_hex >> (4 * d);
          if (tmp[3:0] != 4'd0) top = d;
        end
        lit = m_valid && !m_act_blank[slot] && (slot <= top)
              && !(bus.blink_en && ((m_nb / B) % 2 == 1));
        if (lit) begin
          tmp   = m_act_hex >> (4 * slot);
          e_dig = ~(one << slot);
          e_seg = {~m_act_dp[slot], seg_tab[tmp[3:0]][6:0]};
        end else begin
          e_dig = 4'hF;
          e_seg = 8'hFF;
        end
      end else if (w == D) begin
        e_dig = 4'hF;
        e_seg = 8'hFF;
      end
    end
    if (bnd) begin
      e_fd = 1;
      if (m_pend) begin
        m_act_hex = m_pend_hex; m_act_blank = m_pend_blank; m_act_dp = m_pend_dp;
        m_valid = 1; m_pend = 0; e_ack = 1;
      end
    end
    if (bus.load) begin
      m_pend_hex = bus.hex_in; m_pend_blank = bus.blank_in; m_pend_dp = bus.dp_in;
      m_pend = 1;
    end
    if (!bus.blink_en) m_nb = 0;
    else if (bnd) m_nb++;
  endtask

  task automatic check(input string tag);
    tests++;
    assert (bus.digit_n === e_dig) else begin
      fails++;
      $error("FAIL %s digit_n k=%0d got %b exp %b", tag, k, bus.digit_n, e_dig);
    end
    tests++;
    assert (bus.segments_n === e_seg) else begin
      fails++;
      $error("FAIL %s segments_n k=%0d got %h exp %h", tag, k, bus.segments_n, e_seg);
    end
    tests++;
    assert (bus.load_ack === e_ack) else begin
      fails++;
      $error("FAIL %s load_ack k=%0d got %b exp %b", tag, k, bus.load_ack, e_ack);
    end
    tests++;
    assert (bus.frame_done === e_fd) else begin
      fails++;
      $error("FAIL %s frame_done k=%0d got %b exp %b", tag, k, bus.frame_done, e_fd);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] bl, input logic [3:0] dp, input string tag);
    bus.hex_in = h; bus.blank_in = bl; bus.dp_in = dp; bus.load = 1'b1;
    cyc(tag);
    bus.load = 1'b0;
  endtask

  function automatic bit next_is_boundary();
    int m;
    m = k + 1 - G;
    return (m >= 0) && (m % FRAME == FRAME - G);
  endfunction

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    bus.hex_in = '0; bus.blank_in = '0; bus.dp_in = '0; bus.load = 1'b0; bus.blink_en = 1'b0;
    model_reset();
    run(3, "reset");
    #1 rst_n = 1'b1;
    model_reset();

    do_load(16'h1234, 4'b0000, 4'b0000, "load1234");
    run(3 * FRAME, "show1234");

    do_load(16'h0005, 4'b0000, 4'b0000, "load0005");
    run(2 * FRAME, "lzs0005");
    do_load(16'h0000, 4'b0000, 4'b0000, "load0000");
    run(2 * FRAME, "lzs0000");

    for (int i = 0; i < FRAME && !next_is_boundary(); i++) cyc("sync");
    cyc("sync");
    do_load(16'hAAAA, 4'b0000, 4'b0000, "loadAAAA");
    run(5, "gap");
    do_load(16'hBBBB, 4'b0000, 4'b0000, "loadBBBB");
    run(2 * FRAME, "showBBBB");

    bus.blink_en = 1'b1;
    run(6 * FRAME, "blink");
    bus.blink_en = 1'b0;
    run(FRAME, "unblink");

    do_load(16'h9876, 4'b0100, 4'b0001, "dpblank");
    run(2 * FRAME, "dpblank");

    for (int i = 0; i < FRAME && !next_is_boundary(); i++) cyc("sync2");
    do_load(16'h00C3, 4'b0000, 4'b0010, "loadonbnd");
    run(2 * FRAME, "afterbnd");

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 5) == 0) bus.blink_en = ~bus.blink_en;
      if ($urandom_range(0, 1) == 1)
        do_load(16'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                4'($urandom), "rndload");
      run($urandom_range(1, 30), "rnd");
    end
    bus.blink_en = 1'b0;
    do_load(16'h0420, 4'b0000, 4'b0000, "preload");
    run(2 * FRAME, "prereset");

    for (int i = 0; i < FRAME && e_dig == 4'hF; i++) cyc("seekdrive");
    cyc("middrive");
    rst_n = 1'b0;
    #1;
    model_reset();
    check("asyncreset");
    run(2, "inreset");
    #1 rst_n = 1'b1;
    model_reset();
    run(2 * FRAME, "darkafter");
    do_load(16'h0042, 4'b0000, 4'b0000, "reload");
    run(2 * FRAME, "reload");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
